// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths, the
// always-execute condition code, shifter encodings and the packed control
// group loaded into the E stage.
package id_ex_reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RA_W_DEF   = 4;

    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    // Decoder control bits travelling with the instruction, plus its valid flag.
    typedef struct packed {
        logic       reg_w;
        logic       mem_to_reg;
        logic       alu_src;
        logic       write_src;
        logic       alu_op;
        logic       branch;
        logic       mem_w;
        logic [1:0] imm_src;
        logic [2:0] reg_src;
        logic [4:0] shamt;
        logic [1:0] shift_ctrl;
        logic [3:0] cond;
        logic [1:0] flag_write;
        logic [3:0] alu_control;
        logic       pred_taken;
        logic       valid;
    } ctrl_t;

    // A bubble writes nothing, resolves no branch and carries the AL condition.
    localparam ctrl_t CTRL_BUBBLE = '{cond: COND_AL, default: '0};

endpackage

// File: rtl/id_ex_reg_pipe_reg_en_clr.sv
// Width-parameterised pipeline flop: async active-low reset and synchronous
// clear both load CLR_VAL; clear outranks enable.
module pipe_reg_en_clr #(
    parameter int           W       = 1,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Reset/clear to the bubble value, otherwise load when enabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= CLR_VAL;
        end else if (clr_i) begin
            data_q <= CLR_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Flush loads a bubble, stall holds, otherwise the
// decode-stage fields are captured on the rising edge.
// Optional macro IDEX_PERF_CNT_EN adds a saturating count of flush edges on
// BubbleCnt; without it BubbleCnt is tied to zero.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic              RegWD,
    input  logic              MemtoRegD,
    input  logic              ALUSrcD,
    input  logic              WriteSrcD,
    input  logic              ALUOpD,
    input  logic              BranchD,
    input  logic              MemWD,
    input  logic [1:0]        ImmSrcD,
    input  logic [2:0]        RegSrcD,
    input  logic [4:0]        shamtD,
    input  logic [1:0]        shiftControlD,
    input  logic [3:0]        CondD,
    input  logic [1:0]        FlagWriteD,
    input  logic [3:0]        ALUControlD,
    input  logic              PredTakenD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] ExtImmD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic [RA_W-1:0]   RA1D,
    input  logic [RA_W-1:0]   RA2D,
    input  logic [RA_W-1:0]   WA3D,
    input  logic              RA1D_valid,
    input  logic              RA2D_valid,
    input  logic              WA3D_valid,
    output logic              RegWE,
    output logic              MemtoRegE,
    output logic              ALUSrcE,
    output logic              WriteSrcE,
    output logic              ALUOpE,
    output logic              BranchE,
    output logic              MemWE,
    output logic [1:0]        ImmSrcE,
    output logic [2:0]        RegSrcE,
    output logic [4:0]        shamtE,
    output logic [1:0]        shiftControlE,
    output logic [3:0]        CondE,
    output logic [1:0]        FlagWriteE,
    output logic [3:0]        ALUControlE,
    output logic              PredTakenE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ExtImmE,
    output logic [DATA_W-1:0] PCPlus4E,
    output logic [RA_W-1:0]   RA1E,
    output logic [RA_W-1:0]   RA2E,
    output logic [RA_W-1:0]   WA3E,
    output logic              RA1E_valid,
    output logic              RA2E_valid,
    output logic              WA3E_valid,
    output logic              ValidE,
    output logic [31:0]       BubbleCnt
);

    localparam int DATA_GRP_W = 4 * DATA_W;
    localparam int ADDR_GRP_W = 3 * RA_W + 3;

    ctrl_t                 ctrl_d, ctrl_q;
    logic [DATA_GRP_W-1:0] data_d, data_q;
    logic [ADDR_GRP_W-1:0] addr_d, addr_q;

    // Gather decoder controls; anything loaded from D is a real instruction.
    always_comb begin
        ctrl_d             = CTRL_BUBBLE;
        ctrl_d.reg_w       = RegWD;
        ctrl_d.mem_to_reg  = MemtoRegD;
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.write_src   = WriteSrcD;
        ctrl_d.alu_op      = ALUOpD;
        ctrl_d.branch      = BranchD;
        ctrl_d.mem_w       = MemWD;
        ctrl_d.imm_src     = ImmSrcD;
        ctrl_d.reg_src     = RegSrcD;
        ctrl_d.shamt       = shamtD;
        ctrl_d.shift_ctrl  = shiftControlD;
        ctrl_d.cond        = CondD;
        ctrl_d.flag_write  = FlagWriteD;
        ctrl_d.alu_control = ALUControlD;
        ctrl_d.pred_taken  = PredTakenD;
        ctrl_d.valid       = 1'b1;
    end

    assign data_d = {RD1D, RD2D, ExtImmD, PCPlus4D};
    assign addr_d = {RA1D, RA2D, WA3D, RA1D_valid, RA2D_valid, WA3D_valid};

    pipe_reg_en_clr #(.W($bits(ctrl_t)), .CLR_VAL(CTRL_BUBBLE)) u_ctrl_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (~StallE),
        .clr_i  (FlushE),
        .d_i    (ctrl_d),
        .q_o    (ctrl_q)
    );

    pipe_reg_en_clr #(.W(DATA_GRP_W), .CLR_VAL('0)) u_data_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (~StallE),
        .clr_i  (FlushE),
        .d_i    (data_d),
        .q_o    (data_q)
    );

    pipe_reg_en_clr #(.W(ADDR_GRP_W), .CLR_VAL('0)) u_addr_reg (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (~StallE),
        .clr_i  (FlushE),
        .d_i    (addr_d),
        .q_o    (addr_q)
    );

    assign RegWE         = ctrl_q.reg_w;
    assign MemtoRegE     = ctrl_q.mem_to_reg;
    assign ALUSrcE       = ctrl_q.alu_src;
    assign WriteSrcE     = ctrl_q.write_src;
    assign ALUOpE        = ctrl_q.alu_op;
    assign BranchE       = ctrl_q.branch;
    assign MemWE         = ctrl_q.mem_w;
    assign ImmSrcE       = ctrl_q.imm_src;
    assign RegSrcE       = ctrl_q.reg_src;
    assign shamtE        = ctrl_q.shamt;
    assign shiftControlE = ctrl_q.shift_ctrl;
    assign CondE         = ctrl_q.cond;
    assign FlagWriteE    = ctrl_q.flag_write;
    assign ALUControlE   = ctrl_q.alu_control;
    assign PredTakenE    = ctrl_q.pred_taken;
    assign ValidE        = ctrl_q.valid;

    assign {RD1E, RD2E, ExtImmE, PCPlus4E} = data_q;
    assign {RA1E, RA2E, WA3E, RA1E_valid, RA2E_valid, WA3E_valid} = addr_q;

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // One count per flush edge, sticking at all-ones.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (FlushE && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    // Counter state, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign BubbleCnt = bubble_cnt_q;
`else
    assign BubbleCnt = '0;
`endif

endmodule
